// File: rtl/dut_run_seq.sv
// dut_run_seq -- run sequencer for a processor DUT.
//
// Runs a batch of NUM_PROGS programs. For each program it:
//   1. holds the DUT in reset for RST_CYCLES cycles,
//   2. releases reset and counts RUN cycles until dut_done or until
//      TIMEOUT cycles have passed without it,
//   3. moves on to the next program index.
// When the batch ends it reports all_done and waits for the next start.
//
// Optional feature (compile-time macro RUN_SEQ_STOP_ON_TIMEOUT_EN):
//   defined   - a timed-out program ends the batch; prog_sel keeps the
//               index of the hung program.
//   undefined - every program of the batch runs, timeouts or not.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   start        in   one-cycle batch request (ignored while busy)
//   dut_done     in   DUT completion level, only looked at in RUN
//   dut_reset    out  active-high reset to the DUT
//   prog_sel     out  current program index (selects instruction memory)
//   busy         out  batch in progress
//   run_done     out  one-cycle pulse when a program ends (done or timeout)
//   run_timeout  out  sticky for the batch: some program hit TIMEOUT
//   cycle_count  out  RUN cycles of the current or last program
//   all_done     out  level, batch finished
//   fsm_state    out  current FSM state encoding, for observation
//
// Handshake: start is a single-cycle request sampled on a rising edge;
// it is acted on only in IDLE or FINISH and dropped in every other state.
//
// All outputs are registers; the combinational block computes the next
// value of every register and the sequential block only loads them.

module dut_run_seq #(
  parameter int NUM_PROGS  = 3,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 16,
  localparam int PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_done,
  output logic             dut_reset,
  output logic [PW-1:0]    prog_sel,
  output logic             busy,
  output logic             run_done,
  output logic             run_timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic             all_done,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_RUN    = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [PW-1:0]    LAST_PROG = PW'(NUM_PROGS - 1);
  localparam logic [RW-1:0]    LAST_RST  = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);

  state_t           state, state_n;
  logic [RW-1:0]    rst_cnt, rst_cnt_n;
  logic [PW-1:0]    prog_n;
  logic [CNT_W-1:0] cnt_n, cnt_inc;
  logic             busy_n, run_done_n, to_n, all_done_n, dut_reset_n;
  logic             launch, stop_batch;

  assign cnt_inc   = cycle_count + 1'b1;
  assign fsm_state = state;
  // start only counts where a batch is not already running.
  assign launch    = start && ((state == S_IDLE) || (state == S_FINISH));

`ifdef RUN_SEQ_STOP_ON_TIMEOUT_EN
  // run_timeout is first set on the RUN->NEXT edge, so seeing it in NEXT
  // means the program that just ended is the one that hung.
  assign stop_batch = run_timeout;
`else
  assign stop_batch = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    rst_cnt_n   = rst_cnt;
    prog_n      = prog_sel;
    cnt_n       = cycle_count;
    busy_n      = busy;
    run_done_n  = 1'b0;
    to_n        = run_timeout;
    all_done_n  = all_done;
    dut_reset_n = 1'b1;

    case (state)
      S_IDLE: ;

      S_RST: begin
        if (rst_cnt == LAST_RST) begin
          // Reset released together with the move into RUN so that the
          // first RUN cycle already sees dut_reset low.
          state_n     = S_RUN;
          dut_reset_n = 1'b0;
        end else begin
          rst_cnt_n = rst_cnt + 1'b1;
        end
      end

      S_RUN: begin
        // The count includes the cycle in which done/timeout is sampled.
        cnt_n       = cnt_inc;
        dut_reset_n = 1'b0;
        if (dut_done) begin
          // done wins over a simultaneous timeout
          state_n     = S_NEXT;
          run_done_n  = 1'b1;
          dut_reset_n = 1'b1;
        end else if (cnt_inc == TMO) begin
          state_n     = S_NEXT;
          run_done_n  = 1'b1;
          to_n        = 1'b1;
          dut_reset_n = 1'b1;
        end
      end

      S_NEXT: begin
        if (stop_batch || (prog_sel == LAST_PROG)) begin
          state_n    = S_FINISH;
          busy_n     = 1'b0;
          all_done_n = 1'b1;
        end else begin
          state_n   = S_RST;
          prog_n    = prog_sel + 1'b1;
          rst_cnt_n = '0;
          cnt_n     = '0;
        end
      end

      S_FINISH: ;

      default: state_n = S_IDLE;
    endcase

    // Batch launch from IDLE or FINISH; overrides the hold values above.
    if (launch) begin
      state_n    = S_RST;
      rst_cnt_n  = '0;
      prog_n     = '0;
      cnt_n      = '0;
      to_n       = 1'b0;
      busy_n     = 1'b1;
      all_done_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      prog_sel    <= '0;
      cycle_count <= '0;
      busy        <= 1'b0;
      run_done    <= 1'b0;
      run_timeout <= 1'b0;
      all_done    <= 1'b0;
      dut_reset   <= 1'b1;
    end else begin
      state       <= state_n;
      rst_cnt     <= rst_cnt_n;
      prog_sel    <= prog_n;
      cycle_count <= cnt_n;
      busy        <= busy_n;
      run_done    <= run_done_n;
      run_timeout <= to_n;
      all_done    <= all_done_n;
      dut_reset   <= dut_reset_n;
    end
  end

endmodule

// File: tb/tb_dut_run_seq.sv
// Directed bench for dut_run_seq with NUM_PROGS=3, RST_CYCLES=2,
// TIMEOUT=20, CNT_W=8. Inputs change 1 ns after a rising edge and outputs
// are checked at that same point, well away from the next edge.

module tb_dut_run_seq;

  localparam int NUM_PROGS  = 3;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 20;
  localparam int CNT_W      = 8;
  localparam int PW         = 2;

  localparam int ST_IDLE   = 0;
  localparam int ST_FINISH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             dut_done;
  logic             dut_reset;
  logic [PW-1:0]    prog_sel;
  logic             busy;
  logic             run_done;
  logic             run_timeout;
  logic [CNT_W-1:0] cycle_count;
  logic             all_done;
  logic [2:0]       fsm_state;

  int errors = 0;
  int checks = 0;
  int done_pulses = 0;

  dut_run_seq #(
    .NUM_PROGS (NUM_PROGS),
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dut_done   (dut_done),
    .dut_reset  (dut_reset),
    .prog_sel   (prog_sel),
    .busy       (busy),
    .run_done   (run_done),
    .run_timeout(run_timeout),
    .cycle_count(cycle_count),
    .all_done   (all_done),
    .fsm_state  (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=hang required=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_busy", busy, 1);
    check("launch_all_done", all_done, 0);
    check("launch_count", cycle_count, 0);
    check("launch_timeout", run_timeout, 0);
  endtask

  // Called just after the edge that entered RST. done_after=0 means the
  // program never signals done. noise drives start and dut_done during
  // the first RST cycle; both must have no effect.
  task automatic run_prog(input int pidx, input int done_after, input int exp_low,
                          input int exp_count, input int exp_to, input bit noise);
    int low;
    int guard;
    check("rst_prog_sel", prog_sel, pidx);
    check("rst_dut_reset", dut_reset, 1);
    if (noise) begin
      start    = 1'b1;
      dut_done = 1'b1;
    end
    tick();
    start    = 1'b0;
    dut_done = 1'b0;
    check("rst2_dut_reset", dut_reset, 1);
    tick();
    low   = 0;
    guard = 0;
    while (dut_reset == 1'b0 && guard < 100) begin
      low++;
      if (low == done_after) dut_done = 1'b1;
      tick();
      dut_done = 1'b0;
      guard++;
    end
    check("low_cycles", low, exp_low);
    check("run_done_pulse", run_done, 1);
    if (run_done === 1'b1) done_pulses++;
    check("end_count", cycle_count, exp_count);
    check("end_timeout", run_timeout, exp_to);
    tick();
    check("run_done_clear", run_done, 0);
  endtask

  task automatic check_finish(input int exp_prog, input int exp_count, input int exp_to);
    check("fin_all_done", all_done, 1);
    check("fin_busy", busy, 0);
    check("fin_prog_sel", prog_sel, exp_prog);
    check("fin_count", cycle_count, exp_count);
    check("fin_timeout", run_timeout, exp_to);
    check("fin_state", fsm_state, ST_FINISH);
    check("fin_dut_reset", dut_reset, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dut_reset"}, dut_reset, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_prog_sel"}, prog_sel, 0);
    check({tag, "_count"}, cycle_count, 0);
    check({tag, "_all_done"}, all_done, 0);
    check({tag, "_run_done"}, run_done, 0);
    check({tag, "_timeout"}, run_timeout, 0);
    check({tag, "_state"}, fsm_state, ST_IDLE);
  endtask

  // directed stimulus and checks
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dut_done = 1'b0;

    // reset held for two cycles
    tick(2);
    check_reset_values("por");
    reset = 1'b0;
    tick();
    check("idle_dut_reset", dut_reset, 1);

    // dut_done outside RUN is ignored while idle
    dut_done = 1'b1;
    tick();
    dut_done = 1'b0;
    check("idle_done_ignored", busy, 0);

    // batch: programs finish after 5, 7 and 3 RUN cycles
    launch();
    run_prog(0, 5, 5, 5, 0, 1'b0);
    run_prog(1, 7, 7, 7, 0, 1'b0);
    run_prog(2, 3, 3, 3, 0, 1'b0);
    check("pulses_batch1", done_pulses, 3);
    check_finish(2, 3, 0);

    // FINISH holds with no start
    tick(3);
    check_finish(2, 3, 0);

    // restart from FINISH; start and dut_done noise during RST; the last
    // program raises done exactly on the timeout cycle (done wins)
    launch();
    run_prog(0, 4, 4, 4, 0, 1'b1);
    run_prog(1, 2, 2, 2, 0, 1'b1);
    run_prog(2, TIMEOUT, TIMEOUT, TIMEOUT, 0, 1'b0);
    check("pulses_batch2", done_pulses, 6);
    check_finish(2, TIMEOUT, 0);

    // program 1 hangs
    launch();
    run_prog(0, 3, 3, 3, 0, 1'b0);
    run_prog(1, 0, TIMEOUT, TIMEOUT, 1, 1'b0);
`ifdef RUN_SEQ_STOP_ON_TIMEOUT_EN
    check_finish(1, TIMEOUT, 1);
`else
    run_prog(2, 2, 2, 2, 1, 1'b0);
    check_finish(2, 2, 1);
`endif

    // reset during the third RUN cycle of program 1
    launch();
    run_prog(0, 2, 2, 2, 0, 1'b0);
    check("mid_prog_sel", prog_sel, 1);
    tick(2);
    check("mid_run_low", dut_reset, 0);
    tick(2);
    check("mid_count", cycle_count, 2);
    reset = 1'b1;
    tick();
    check_reset_values("midrun");
    reset = 1'b0;
    tick();
    check("post_reset_idle", fsm_state, ST_IDLE);

    // later start runs from program 0
    launch();
    run_prog(0, 1, 1, 1, 0, 1'b0);
    run_prog(1, 6, 6, 6, 0, 1'b0);
    run_prog(2, 4, 4, 4, 0, 1'b0);
    check_finish(2, 4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
